// File: rtl/memory_port_arbiter.sv
// Shares one fixed-latency memory port between instruction fetch and data access, one request at a time.
// Optional ARBITER_ROUND_ROBIN_EN: alternate grants on simultaneous requests; otherwise data always wins.
module memory_port_arbiter #(
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_ready,
    output logic [31:0] inst_data,
    input  logic        data_req,
    input  logic        data_write,
    input  logic [31:0] data_addr,
    input  logic [63:0] data_write_data,
    input  logic [2:0]  data_width,
    output logic        data_ready,
    output logic [63:0] data_read_data,
    output logic        mem_read_en,
    output logic        mem_write_en,
    output logic [31:0] mem_addr,
    output logic [63:0] mem_write_data,
    output logic [2:0]  mem_width,
    input  logic [63:0] mem_data_fetched
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam logic [3:0] LAST_CNT   = 4'(MEM_LATENCY - 1);
    localparam logic [2:0] WORD_WIDTH = 3'b010;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        grant_data_q, grant_data_d;
    logic        write_q, write_d;
    logic [31:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [2:0]  width_q, width_d;
    logic [63:0] rdata_q, rdata_d;
    logic        pick_data;

`ifdef ARBITER_ROUND_ROBIN_EN
    logic last_data_q, last_data_d;

    // Contention goes to whoever was not served last; a lone request always wins.
    always_comb begin
        pick_data = data_req && (!inst_req || !last_data_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_data_q <= 1'b1;
        end else begin
            last_data_q <= last_data_d;
        end
    end

    always_comb begin
        last_data_d = last_data_q;
        if (state_q == S_IDLE && (inst_req || data_req)) begin
            last_data_d = pick_data;
        end
    end
`else
    always_comb begin
        pick_data = data_req;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            grant_data_q <= 1'b0;
            write_q      <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 64'd0;
            width_q      <= 3'd0;
            rdata_q      <= 64'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            grant_data_q <= grant_data_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            width_q      <= width_d;
            rdata_q      <= rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        grant_data_d = grant_data_q;
        write_d      = write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        width_d      = width_q;
        rdata_d      = rdata_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = 4'd0;
                if (inst_req || data_req) begin
                    grant_data_d = pick_data;
                    write_d      = pick_data && data_write;
                    addr_d       = pick_data ? data_addr : inst_addr;
                    wdata_d      = pick_data ? data_write_data : 64'd0;
                    width_d      = pick_data ? data_width : WORD_WIDTH;
                    state_d      = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (cnt_q == LAST_CNT) begin
                    // Stores return zero read data, so nothing from the bus is kept.
                    rdata_d = write_q ? 64'd0 : mem_data_fetched;
                    cnt_d   = 4'd0;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        inst_ready     = 1'b0;
        inst_data      = 32'd0;
        data_ready     = 1'b0;
        data_read_data = 64'd0;
        mem_read_en    = 1'b0;
        mem_write_en   = 1'b0;
        mem_addr       = 32'd0;
        mem_write_data = 64'd0;
        mem_width      = 3'd0;
        case (state_q)
            S_ACCESS: begin
                mem_read_en    = !write_q;
                mem_write_en   = write_q;
                mem_addr       = addr_q;
                mem_write_data = wdata_q;
                mem_width      = width_q;
            end
            S_RESP: begin
                if (grant_data_q) begin
                    data_ready     = 1'b1;
                    data_read_data = rdata_q;
                end else begin
                    inst_ready = 1'b1;
                    inst_data  = rdata_q[31:0];
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Bench for memory_port_arbiter: instance a uses MEM_LATENCY=1, instance b uses MEM_LATENCY=3.
// Stimulus pushes expected transactions; a negedge monitor checks memory-side and ready-side activity against them.
module tb_memory_port_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        inst_req_a, inst_ready_a, data_req_a, data_write_a, data_ready_a;
    logic [31:0] inst_addr_a, inst_data_a, data_addr_a, mem_addr_a;
    logic [63:0] data_write_data_a, data_read_data_a, mem_write_data_a, mem_data_fetched_a;
    logic [2:0]  data_width_a, mem_width_a;
    logic        mem_read_en_a, mem_write_en_a;

    logic        inst_req_b, inst_ready_b, data_req_b, data_write_b, data_ready_b;
    logic [31:0] inst_addr_b, inst_data_b, data_addr_b, mem_addr_b;
    logic [63:0] data_write_data_b, data_read_data_b, mem_write_data_b, mem_data_fetched_b;
    logic [2:0]  data_width_b, mem_width_b;
    logic        mem_read_en_b, mem_write_en_b;

    memory_port_arbiter #(.MEM_LATENCY(1)) u_dut_a (
        .clk(clk), .rst(rst),
        .inst_req(inst_req_a), .inst_addr(inst_addr_a), .inst_ready(inst_ready_a), .inst_data(inst_data_a),
        .data_req(data_req_a), .data_write(data_write_a), .data_addr(data_addr_a),
        .data_write_data(data_write_data_a), .data_width(data_width_a),
        .data_ready(data_ready_a), .data_read_data(data_read_data_a),
        .mem_read_en(mem_read_en_a), .mem_write_en(mem_write_en_a), .mem_addr(mem_addr_a),
        .mem_write_data(mem_write_data_a), .mem_width(mem_width_a), .mem_data_fetched(mem_data_fetched_a)
    );

    memory_port_arbiter #(.MEM_LATENCY(3)) u_dut_b (
        .clk(clk), .rst(rst),
        .inst_req(inst_req_b), .inst_addr(inst_addr_b), .inst_ready(inst_ready_b), .inst_data(inst_data_b),
        .data_req(data_req_b), .data_write(data_write_b), .data_addr(data_addr_b),
        .data_write_data(data_write_data_b), .data_width(data_width_b),
        .data_ready(data_ready_b), .data_read_data(data_read_data_b),
        .mem_read_en(mem_read_en_b), .mem_write_en(mem_write_en_b), .mem_addr(mem_addr_b),
        .mem_write_data(mem_write_data_b), .mem_width(mem_width_b), .mem_data_fetched(mem_data_fetched_b)
    );

    function automatic logic [63:0] mem_val(logic [31:0] a);
        case (a)
            32'h0000_0040: mem_val = 64'h0000_0000_0050_0093;
            32'h0000_0044: mem_val = 64'h0000_0000_00A0_0113;
            32'h1000_0010: mem_val = 64'h0123_4567_89AB_CDEF;
            default:       mem_val = {a, ~a};
        endcase
    endfunction

    // Read data appears only in the MEM_LATENCY-th consecutive read cycle; otherwise garbage.
    int rdcnt_a = 0;
    int rdcnt_b = 0;
    always @(posedge clk) rdcnt_a <= (rst || !mem_read_en_a) ? 0 : rdcnt_a + 1;
    always @(posedge clk) rdcnt_b <= (rst || !mem_read_en_b) ? 0 : rdcnt_b + 1;
    assign mem_data_fetched_a = (mem_read_en_a && rdcnt_a == 0) ? mem_val(mem_addr_a) : 64'hBAD0_BAD0_BAD0_BAD0;
    assign mem_data_fetched_b = (mem_read_en_b && rdcnt_b == 2) ? mem_val(mem_addr_b) : 64'hBAD0_BAD0_BAD0_BAD0;

    typedef struct {
        int          dut;
        bit          is_data;
        bit          is_write;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [2:0]  width;
        logic [63:0] rdata;
        int          rdy_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   en_cnt[2];
    bit   abort_win = 1'b0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic push(int g, bit d, bit w, logic [31:0] a, logic [63:0] wd, logic [2:0] wid,
                        logic [63:0] rd, int rc);
        exp_t e;
        e.dut = g; e.is_data = d; e.is_write = w; e.addr = a; e.wdata = wd;
        e.width = wid; e.rdata = rd; e.rdy_cyc = rc;
        exp_q.push_back(e);
    endtask

    task automatic mon(int g, int lat, logic ir, logic [31:0] idat, logic dr, logic [63:0] ddat,
                       logic re, logic we, logic [31:0] ma, logic [63:0] mwd, logic [2:0] mw);
        exp_t e;
        if (abort_win) begin
            chk("no_ready_during_reset", 64'({ir, dr}), 64'd0);
            en_cnt[g] = 0;
            return;
        end
        if (re || we) begin
            chk("single_enable", 64'(re && we), 64'd0);
            chk("access_expected", 64'(exp_q.size() > 0 && exp_q[0].dut == g), 64'd1);
            if (exp_q.size() > 0 && exp_q[0].dut == g) begin
                e = exp_q[0];
                chk("mem_write_en", 64'(we), 64'(e.is_write));
                chk("mem_addr", 64'(ma), 64'(e.addr));
                chk("mem_width", 64'(mw), 64'(e.width));
                if (e.is_write) chk("mem_write_data", mwd, e.wdata);
                en_cnt[g]++;
            end
        end
        if (ir || dr) begin
            chk("single_ready", 64'(ir && dr), 64'd0);
            chk("ready_expected", 64'(exp_q.size() > 0 && exp_q[0].dut == g), 64'd1);
            if (exp_q.size() > 0 && exp_q[0].dut == g) begin
                e = exp_q.pop_front();
                chk("ready_kind", 64'(dr), 64'(e.is_data));
                chk("ready_cycle", 64'(cyc), 64'(e.rdy_cyc));
                chk("access_cycles", 64'(en_cnt[g]), 64'(lat));
                if (e.is_data) chk("data_read_data", ddat, e.rdata);
                else           chk("inst_data", 64'(idat), 64'(e.rdata[31:0]));
            end
            en_cnt[g] = 0;
        end
    endtask

    always @(negedge clk) begin
        mon(0, 1, inst_ready_a, inst_data_a, data_ready_a, data_read_data_a,
            mem_read_en_a, mem_write_en_a, mem_addr_a, mem_write_data_a, mem_width_a);
        mon(1, 3, inst_ready_b, inst_data_b, data_ready_b, data_read_data_b,
            mem_read_en_b, mem_write_en_b, mem_addr_b, mem_write_data_b, mem_width_b);
    end

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_idle(int g, string tag);
        if (g == 0) begin
            chk({tag, "_ctl_a"}, 64'({inst_ready_a, data_ready_a, mem_read_en_a, mem_write_en_a, mem_width_a}), 64'd0);
            chk({tag, "_addr_a"}, 64'(mem_addr_a), 64'd0);
            chk({tag, "_data_a"}, data_read_data_a | mem_write_data_a | 64'(inst_data_a), 64'd0);
        end else begin
            chk({tag, "_ctl_b"}, 64'({inst_ready_b, data_ready_b, mem_read_en_b, mem_write_en_b, mem_width_b}), 64'd0);
            chk({tag, "_addr_b"}, 64'(mem_addr_b), 64'd0);
            chk({tag, "_data_b"}, data_read_data_b | mem_write_data_b | 64'(inst_data_b), 64'd0);
        end
    endtask

    initial begin
        int  k;
        bit  first_data;
        en_cnt[0] = 0; en_cnt[1] = 0;
        rst = 1'b1;
        inst_req_a = 0; inst_addr_a = 0; data_req_a = 0; data_write_a = 0;
        data_addr_a = 0; data_write_data_a = 0; data_width_a = 0;
        inst_req_b = 0; inst_addr_b = 0; data_req_b = 0; data_write_b = 0;
        data_addr_b = 0; data_write_data_b = 0; data_width_b = 0;
        tick(2);
        rst = 1'b0;
        @(negedge clk);
        check_idle(0, "reset_state");
        check_idle(1, "reset_state");
        tick(2);

        // Fetch, latency 1.
        k = cyc;
        inst_req_a = 1; inst_addr_a = 32'h0000_0040;
        push(0, 0, 0, 32'h0000_0040, 64'd0, 3'b010, 64'h0000_0000_0050_0093, k + 2);
        tick(3);
        inst_req_a = 0;
        tick(2);

        // Store, latency 1.
        k = cyc;
        data_req_a = 1; data_write_a = 1; data_addr_a = 32'h1000_0008;
        data_write_data_a = 64'hDEAD_BEEF_0BAD_F00D; data_width_a = 3'b011;
        push(0, 1, 1, 32'h1000_0008, 64'hDEAD_BEEF_0BAD_F00D, 3'b011, 64'd0, k + 2);
        tick(3);
        data_req_a = 0; data_write_a = 0;
        tick(2);

        // Reset for two cycles in the middle of a latency-3 store.
        data_req_b = 1; data_write_b = 1; data_addr_b = 32'h1000_0020;
        data_write_data_b = 64'h1111_2222_3333_4444; data_width_b = 3'b011;
        tick(1);
        rst = 1'b1; abort_win = 1'b1; data_req_b = 0; data_write_b = 0;
        tick(1);
        @(negedge clk);
        check_idle(1, "reset_abort");
        tick(1);
        rst = 1'b0;
        @(negedge clk);
        check_idle(1, "after_reset");
        tick(1);
        abort_win = 1'b0;
        tick(2);

        // Simultaneous requests straight after reset.
`ifdef ARBITER_ROUND_ROBIN_EN
        first_data = 1'b0;
`else
        first_data = 1'b1;
`endif
        k = cyc;
        inst_req_a = 1; inst_addr_a = 32'h0000_0044;
        data_req_a = 1; data_write_a = 0; data_addr_a = 32'h1000_0018; data_width_a = 3'b100;
        if (first_data) begin
            push(0, 1, 0, 32'h1000_0018, 64'd0, 3'b100, mem_val(32'h1000_0018), k + 2);
            push(0, 0, 0, 32'h0000_0044, 64'd0, 3'b010, 64'h0000_0000_00A0_0113, k + 5);
        end else begin
            push(0, 0, 0, 32'h0000_0044, 64'd0, 3'b010, 64'h0000_0000_00A0_0113, k + 2);
            push(0, 1, 0, 32'h1000_0018, 64'd0, 3'b100, mem_val(32'h1000_0018), k + 5);
        end
        tick(3);
        if (first_data) data_req_a = 0; else inst_req_a = 0;
        tick(3);
        data_req_a = 0; inst_req_a = 0;
        tick(2);

        // Load, latency 3.
        k = cyc;
        data_req_b = 1; data_write_b = 0; data_addr_b = 32'h1000_0010; data_width_b = 3'b011;
        push(1, 1, 0, 32'h1000_0010, 64'd0, 3'b011, 64'h0123_4567_89AB_CDEF, k + 4);
        tick(5);
        data_req_b = 0;
        tick(2);

        // Fetch request held through the response: a second, separate fetch.
        k = cyc;
        inst_req_a = 1; inst_addr_a = 32'h0000_0040;
        push(0, 0, 0, 32'h0000_0040, 64'd0, 3'b010, 64'h0000_0000_0050_0093, k + 2);
        push(0, 0, 0, 32'h0000_0040, 64'd0, 3'b010, 64'h0000_0000_0050_0093, k + 5);
        tick(6);
        inst_req_a = 0;
        tick(5);

        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
